regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NREQ writeback requesters
//  (ALU=0, load=1, jal link=2 by default). Round-robin arbitration, valid/ready per
//  requester, one registered write per cycle to the register file write port.
//  Also exports a pending-write mask so the issue stage can stall on RAW hazards.
// PARAMETERS
//  NREQ   3   number of writeback requesters (2..8)
//  AW     5   register address width (32 registers)
//  DW     32  write data width
// PORTS
//  clock         in   1         rising-edge clock
//  reset         in   1         synchronous, active-high reset
//  hold          in   1         freeze: no grants while high
//  req_valid     in   NREQ      requester i has a write pending
//  req_ready     out  NREQ      one-hot grant; transfer when valid&ready
//  req_rd        in   NREQ*AW   dest reg of requester i, slice [i*AW +: AW]
//  req_data      in   NREQ*DW   write data of requester i, slice [i*DW +: DW]
//  rf_we         out  1         register file write enable (registered)
//  rf_waddr      out  AW        register file write address (registered)
//  rf_wdata      out  DW        register file write data (registered)
//  grant_id      out  3         index of last accepted requester (registered)
//  pending_mask  out  2**AW     bit r set if any write to reg r is pending/in flight
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, grant_id=0, RR pointer=0; req_ready=0
//    during the reset cycle. Reset dominates hold and all requests.
//  - Grant (combinational): if !hold and !reset, req_ready = one-hot of first valid
//    requester scanning ptr, ptr+1, ... wrapping mod NREQ; else all zero.
//    req_ready never depends on req_data/req_rd. At most one bit set.
//  - Transfer on edge where req_valid[i]&req_ready[i]. Next cycle: rf_we=1 (0 if
//    rd==0), rf_waddr=rd, rf_wdata=data, grant_id=i. Latency accept->write 1 cycle.
//  - No transfer in a cycle: rf_we=0 next cycle; rf_waddr/rf_wdata/grant_id hold.
//  - RR pointer: after transfer from i, ptr <= (i+1) mod NREQ; otherwise unchanged.
//    Writes to r0 still advance the pointer (accepted and discarded).
//  - Requesters hold valid, rd, data stable until accepted; dropping valid without
//    a transfer is legal (request withdrawn, no write).
//  - Throughput: one write/cycle; with all NREQ valid continuously each requester
//    is served exactly once per NREQ cycles (no starvation).
//  - Same rd from two requesters: both written in grant order; later grant wins.
//  - pending_mask (combinational) = OR over i of decode(req_rd[i]) for req_valid[i]
//    OR decode(rf_waddr) when rf_we. Bit 0 always 0.
//  - hold asserted mid-stream: grants stop same cycle; the write already registered
//    still issues (rf_we=1 for one cycle), then rf_we=0 until hold drops.
//  - Reset mid-operation: in-flight registered write is dropped (rf_we=0 next cycle);
//    accepted-but-unwritten data is lost by design.
// TESTING
//  1 reset 2 cycles, all valid=0 -> rf_we=0, waddr=0, wdata=0, grant_id=0, ready=000.
//  2 only req1 valid, rd=7, data=0x0000_00AA -> ready=010 same cycle; next cycle
//    rf_we=1, waddr=7, wdata=0xAA, grant_id=1; pending_mask[7]=1 both cycles.
//  3 all three valid continuously (rd 3/4/5) from ptr=0 -> grants 0,1,2,0,1,2; rf_we=1
//    every cycle after first; waddr sequence 3,4,5,3,4,5.
//  4 req2 valid rd=0 data=0xDEAD -> ready[2]=1, next cycle rf_we=0, grant_id=2, ptr->0;
//    pending_mask stays 0.
//  5 reqs 0,1 valid, hold=1 for 3 cycles -> ready=000, rf_we=0 after one cycle;
//    hold=0 -> req0 granted first, then req1.
//  6 req0 and req2 both rd=9 data 0x11/0x22 -> two writes to r9, final value 0x22;
//    assert reset while req valid -> ready=000, rf_we=0 next cycle, ptr=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port among NREQ writeback
//   requesters using round-robin arbitration. An accepted request is written
//   to the register file one cycle later through registered outputs. A
//   pending-write mask lets the issue stage stall on RAW hazards.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   hold          freeze: no grants while high
//   req_valid     per-requester write pending
//   req_ready     one-hot grant (combinational); transfer when valid & ready
//   req_rd        destination register of requester i at [i*AW +: AW]
//   req_data      write data of requester i at [i*DW +: DW]
//   rf_we         register file write enable (registered)
//   rf_waddr      register file write address (registered)
//   rf_wdata      register file write data (registered)
//   grant_id      index of the last accepted requester (registered)
//   pending_mask  bit r set while a write to register r is requested or in flight
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [DW-1:0]        rf_wdata,
  output logic [2:0]           grant_id,
  output logic [(2**AW)-1:0]   pending_mask
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2**AW;

  // One-hot decode of a register address.
  function automatic logic [NREG-1:0] decode_reg(input logic [AW-1:0] addr);
    logic [NREG-1:0] onehot;
    onehot       = '0;
    onehot[addr] = 1'b1;
    return onehot;
  endfunction

  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   ptr_next_s;
  logic [PW-1:0]   sel_s;
  logic [PW-1:0]   idx_s;
  logic            grant_en_s;
  logic            found_s;
  logic            hit_s;
  logic            xfer_s;
  logic [NREQ-1:0] ready_s;
  logic [AW-1:0]   rd_s;
  logic [DW-1:0]   data_s;
  logic [NREG-1:0] pend_s;

  logic            rf_we_r;
  logic [AW-1:0]   rf_waddr_r;
  logic [DW-1:0]   rf_wdata_r;
  logic [2:0]      grant_id_r;

  // Round-robin grant: first valid requester at or after the pointer, wrapping.
  // Only valid bits, hold and reset feed this path, never rd or data.
  always_comb begin
    ready_s    = '0;
    sel_s      = '0;
    found_s    = 1'b0;
    idx_s      = '0;
    hit_s      = 1'b0;
    grant_en_s = !hold && !reset;
    for (int k = 0; k < NREQ; k++) begin
      idx_s          = PW'((int'(ptr_r) + k) % NREQ);
      hit_s          = grant_en_s && !found_s && req_valid[idx_s];
      found_s        = found_s | hit_s;
      ready_s[idx_s] = ready_s[idx_s] | hit_s;
      sel_s          = hit_s ? idx_s : sel_s;
    end
  end

  // Select the granted requester's rd/data with a one-hot AND-OR mux and
  // compute the pointer value following that requester.
  always_comb begin
    rd_s   = '0;
    data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_s   = rd_s   | (req_rd[i*AW +: AW]   & {AW{ready_s[i]}});
      data_s = data_s | (req_data[i*DW +: DW] & {DW{ready_s[i]}});
    end
    xfer_s     = |(req_valid & ready_s);
    ptr_next_s = (sel_s == PW'(NREQ - 1)) ? '0 : (sel_s + PW'(1));
  end

  // Write-port registers and RR pointer. Writes to r0 are accepted (pointer
  // advances, grant_id updates) but never raise the write enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= '0;
      rf_wdata_r <= '0;
      grant_id_r <= 3'd0;
      ptr_r      <= '0;
    end else if (xfer_s) begin
      rf_we_r    <= (rd_s != '0);
      rf_waddr_r <= rd_s;
      rf_wdata_r <= data_s;
      grant_id_r <= 3'(sel_s);
      ptr_r      <= ptr_next_s;
    end else begin
      rf_we_r    <= 1'b0;
    end
  end

  // Pending writes: every valid request plus the write currently on the port.
  always_comb begin
    pend_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend_s = pend_s | (decode_reg(req_rd[i*AW +: AW]) & {NREG{req_valid[i]}});
    end
    pend_s    = pend_s | (decode_reg(rf_waddr_r) & {NREG{rf_we_r}});
    pend_s[0] = 1'b0;
  end

  assign req_ready    = ready_s;
  assign rf_we        = rf_we_r;
  assign rf_waddr     = rf_waddr_r;
  assign rf_wdata     = rf_wdata_r;
  assign grant_id     = grant_id_r;
  assign pending_mask = pend_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, compared against a behavioural model of the arbiter and of the
// register file contents it produces.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR   = 32;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*DW-1:0]   req_data;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;
  logic [2:0]           grant_id;
  logic [NR-1:0]        pending_mask;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_data     (req_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .grant_id     (grant_id),
    .pending_mask (pending_mask)
  );

  always #5 clock = ~clock;

  // Requester-side stimulus state.
  bit          v   [NREQ];
  int          rdv [NREQ];
  logic [31:0] dv  [NREQ];

  // Behavioural model state.
  int          m_ptr;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_gid;
  logic [31:0] rf_m [NR];
  logic [31:0] rf_d [NR];

  int total;
  int passed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = v[i];
      req_rd[i*AW +: AW]    = AW'(rdv[i]);
      req_data[i*DW +: DW]  = dv[i];
    end
  endtask

  // Expected grant: first valid requester scanning from the pointer, or -1.
  function automatic int pick();
    if (reset || hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: apply inputs, check combinational outputs, clock, update
  // the model and check registered outputs.
  task automatic step();
    int          g;
    logic [2:0]  exp_ready;
    logic [31:0] pm;
    drive();
    #1;
    g         = pick();
    exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
    pm        = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) pm[rdv[i]] = 1'b1;
    end
    if (m_we) pm[m_waddr] = 1'b1;
    pm[0] = 1'b0;
    chk("req_ready", req_ready, exp_ready);
    chk("pending_mask", pending_mask, pm);
    @(posedge clock);
    if (reset) begin
      m_we = 1'b0; m_waddr = 0; m_wdata = 32'd0; m_gid = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_we    = (rdv[g] != 0);
      m_waddr = rdv[g];
      m_wdata = dv[g];
      m_gid   = g;
      m_ptr   = (g + 1) % NREQ;
      v[g]    = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (m_we) rf_m[m_waddr] = m_wdata;
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("grant_id", grant_id, m_gid);
    if (rf_we === 1'b1) rf_d[rf_waddr] = rf_wdata;
  endtask

  initial begin
    total = 0; passed = 0;
    m_ptr = 0; m_we = 1'b0; m_waddr = 0; m_wdata = 32'd0; m_gid = 0;
    for (int r = 0; r < NR; r++) begin
      rf_m[r] = 32'd0;
      rf_d[r] = 32'd0;
    end
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; rdv[i] = 0; dv[i] = 32'd0;
    end
    reset = 1'b1; hold = 1'b0;
    drive();
    @(posedge clock); #1;

    // 1: reset held two cycles, no requests.
    step(); step();
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_grant_id", grant_id, 3'd0);
    reset = 1'b0;

    // 2: single request from requester 1 to r7.
    v[1] = 1'b1; rdv[1] = 7; dv[1] = 32'h0000_00AA;
    step();
    chk("t2_waddr", rf_waddr, 5'd7);
    chk("t2_wdata", rf_wdata, 32'h0000_00AA);
    chk("t2_gid", grant_id, 3'd1);
    chk("t2_pend7", pending_mask[7], 1'b1);

    // 4: write to r0 is accepted and dropped, pointer wraps to 0.
    v[2] = 1'b1; rdv[2] = 0; dv[2] = 32'h0000_DEAD;
    step();
    chk("t4_we", rf_we, 1'b0);
    chk("t4_gid", grant_id, 3'd2);
    chk("t4_pend", pending_mask, 32'd0);

    // 3: all requesters continuously valid, rd 3/4/5, from pointer 0.
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        v[i] = 1'b1; rdv[i] = 3 + i; dv[i] = $urandom;
      end
      step();
      chk("t3_gid", grant_id, 3'(c % 3));
      chk("t3_waddr", rf_waddr, 5'(3 + c % 3));
      chk("t3_we", rf_we, 1'b1);
    end
    v[2] = 1'b0;

    // 5: hold for three cycles with requesters 0 and 1 waiting.
    v[0] = 1'b1; rdv[0] = 20; dv[0] = $urandom;
    v[1] = 1'b1; rdv[1] = 21; dv[1] = $urandom;
    hold = 1'b1;
    step(); step(); step();
    chk("t5_hold_we", rf_we, 1'b0);
    hold = 1'b0;
    step();
    chk("t5_first", grant_id, 3'd0);
    step();
    chk("t5_second", grant_id, 3'd1);

    // Bring the pointer back to 0 through requester 2.
    v[2] = 1'b1; rdv[2] = 12; dv[2] = $urandom;
    step();

    // 6: same destination from two requesters; later grant wins.
    v[0] = 1'b1; rdv[0] = 9; dv[0] = 32'h11;
    v[2] = 1'b1; rdv[2] = 9; dv[2] = 32'h22;
    step(); step();
    chk("t6_r9", rf_d[9], 32'h22);
    // Reset while a request is valid, then pointer restarts at 0.
    v[0] = 1'b1; rdv[0] = 10; dv[0] = $urandom;
    reset = 1'b1;
    step();
    chk("t6_rst_we", rf_we, 1'b0);
    reset = 1'b0;
    v[1] = 1'b1; rdv[1] = 11; dv[1] = $urandom;
    step();
    chk("t6_ptr0", grant_id, 3'd0);

    // Random traffic with occasional withdrawals, holds and resets.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1; rdv[i] = $urandom_range(0, 31); dv[i] = $urandom;
        end else if (v[i] && $urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      hold  = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0; hold = 1'b0;
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    step();

    for (int r = 0; r < NR; r++) begin
      chk("rf_final", rf_d[r], rf_m[r]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

endmodule
